// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// frame_pkg
// Shared constants, frame address helper and fetch FSM encoding.
// Rev 1.0
// ============================================================================
package frame_pkg;

  localparam logic [31:0] FRAME_BASE      = 32'h0001_0000;
  localparam int unsigned BEATS_PER_FRAME = 256;
  localparam logic [7:0]  LAST_BEAT_IDX   = 8'(BEATS_PER_FRAME - 1);
  localparam logic [7:0]  AXI_LEN_FRAME   = 8'(BEATS_PER_FRAME - 1);
  localparam logic [2:0]  AXI_SIZE_16B    = 3'b100;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Each frame occupies one 4 KB page above the base.
  function automatic logic [31:0] frame_offset(input logic [4:0] frame_id);
    return {15'd0, frame_id, 12'h000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_skid.sv
`default_nettype none
// ============================================================================
// axi_rd_skid
// Two-entry valid/ready buffer with registered outputs (output reg + skid reg).
// Rev 1.0
// ============================================================================
module axi_rd_skid #(
  parameter int unsigned WIDTH = 137
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             pop;
  logic             push;

  // The skid register only holds data while the output register is occupied,
  // so it alone marks the buffer full.
  assign in_ready_o  = !skid_valid_q;
  assign pop         = out_valid_q && out_ready_i;
  assign push        = in_valid_i && (!skid_valid_q || pop);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = push;
        if (push) skid_data_d = in_data_i;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = in_data_i;
      end
    end else if (push) begin
      if (out_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_fetch_axi_rd.sv
`default_nettype none
// ============================================================================
// frame_fetch_axi_rd
// AXI4 read master fetching one 256-beat frame and streaming it downstream.
// Rev 1.0
// ============================================================================
module frame_fetch_axi_rd #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE = ADDR_WIDTH'(frame_pkg::FRAME_BASE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [4:0]            req_frame_id,
  output logic                  req_ready,
  output logic [ID_WIDTH-1:0]   arid_s_inf,
  output logic [ADDR_WIDTH-1:0] araddr_s_inf,
  output logic [7:0]            arlen_s_inf,
  output logic [2:0]            arsize_s_inf,
  output logic [1:0]            arburst_s_inf,
  output logic                  arvalid_s_inf,
  input  logic                  arready_s_inf,
  input  logic [ID_WIDTH-1:0]   rid_s_inf,
  input  logic [1:0]            rresp_s_inf,
  input  logic                  rlast_s_inf,
  input  logic [DATA_WIDTH-1:0] rdata_s_inf,
  input  logic                  rvalid_s_inf,
  output logic                  rready_s_inf,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [DATA_WIDTH-1:0] beat_data,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic                  done,
  output logic                  err
);

  import frame_pkg::*;

  localparam int unsigned SKID_W = DATA_WIDTH + 9;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  skid_in_ready;
  logic                  skid_out_valid;
  logic [SKID_W-1:0]     skid_out_data;
  logic                  r_push;
  logic                  push_last;
  logic                  resp_bad;
  logic                  last_pop;

  assign rready_s_inf = (state_q == ST_DATA) && skid_in_ready;
  assign r_push       = rvalid_s_inf && rready_s_inf;
  // A missing rlast on beat 255 still ends the burst, so the frame never overruns.
  assign push_last    = rlast_s_inf || (cnt_q == LAST_BEAT_IDX);
  assign resp_bad     = (rresp_s_inf != AXI_RESP_OKAY) || (rid_s_inf != '0) ||
                        (rlast_s_inf != (cnt_q == LAST_BEAT_IDX));
  assign last_pop     = skid_out_valid && beat_ready && beat_last;

  axi_rd_skid #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (r_push),
    .in_data_i   ({rdata_s_inf, cnt_q, push_last}),
    .in_ready_o  (skid_in_ready),
    .out_valid_o (skid_out_valid),
    .out_data_o  (skid_out_data),
    .out_ready_i (beat_ready)
  );

  assign {beat_data, beat_idx, beat_last} = skid_out_data;
  assign beat_valid    = skid_out_valid;
  assign arid_s_inf    = '0;
  assign araddr_s_inf  = araddr_q;
  assign arlen_s_inf   = AXI_LEN_FRAME;
  assign arsize_s_inf  = AXI_SIZE_16B;
  assign arburst_s_inf = AXI_BURST_INCR;
  assign arvalid_s_inf = arvalid_q;
  assign done          = done_q;
  assign err           = err_q;

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          araddr_d  = FRAME_BASE + ADDR_WIDTH'(frame_offset(req_frame_id));
          arvalid_d = 1'b1;
          cnt_d     = 8'd0;
          err_d     = 1'b0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arvalid_q && arready_s_inf) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_push) begin
          cnt_d = cnt_q + 8'd1;
          if (resp_bad)  err_d   = 1'b1;
          if (push_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_pop) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_fetch_axi_rd.sv
`default_nettype none
// ============================================================================
// tb_frame_fetch_axi_rd
// Directed bench with a behavioural DRAM read slave and a beat recorder.
// Rev 1.0
// ============================================================================
module tb_frame_fetch_axi_rd;

  localparam int REC_DEPTH = 4096;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [4:0]   req_frame_id;
  logic         req_ready;
  logic [3:0]   arid_s_inf;
  logic [31:0]  araddr_s_inf;
  logic [7:0]   arlen_s_inf;
  logic [2:0]   arsize_s_inf;
  logic [1:0]   arburst_s_inf;
  logic         arvalid_s_inf;
  logic         arready_s_inf;
  logic [3:0]   rid_s_inf;
  logic [1:0]   rresp_s_inf;
  logic         rlast_s_inf;
  logic [127:0] rdata_s_inf;
  logic         rvalid_s_inf;
  logic         rready_s_inf;
  logic         beat_valid;
  logic         beat_ready;
  logic [127:0] beat_data;
  logic [7:0]   beat_idx;
  logic         beat_last;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  // Bench controls
  int ar_delay   = 0;
  int early_last = 255;
  bit br_random  = 1'b0;
  bit br_level   = 1'b1;

  // Recorder state
  logic [127:0] rec_data [0:REC_DEPTH-1];
  logic [7:0]   rec_idx  [0:REC_DEPTH-1];
  logic         rec_last [0:REC_DEPTH-1];
  int           rec_total       = 0;
  int           done_total      = 0;
  int           ar_hs_total     = 0;
  int           ar_high_total   = 0;
  int           ar_addr_changes = 0;
  logic [31:0]  ar_last_addr    = '0;
  logic         ar_prev_valid   = 1'b0;
  logic [31:0]  ar_prev_addr    = '0;
  int           occ             = 0;
  int           occ_max         = 0;

  // Snapshots taken at the start of each step
  int s_rec, s_done, s_ar, s_high, s_chg;

  frame_fetch_axi_rd dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_frame_id  (req_frame_id),
    .req_ready     (req_ready),
    .arid_s_inf    (arid_s_inf),
    .araddr_s_inf  (araddr_s_inf),
    .arlen_s_inf   (arlen_s_inf),
    .arsize_s_inf  (arsize_s_inf),
    .arburst_s_inf (arburst_s_inf),
    .arvalid_s_inf (arvalid_s_inf),
    .arready_s_inf (arready_s_inf),
    .rid_s_inf     (rid_s_inf),
    .rresp_s_inf   (rresp_s_inf),
    .rlast_s_inf   (rlast_s_inf),
    .rdata_s_inf   (rdata_s_inf),
    .rvalid_s_inf  (rvalid_s_inf),
    .rready_s_inf  (rready_s_inf),
    .beat_valid    (beat_valid),
    .beat_ready    (beat_ready),
    .beat_data     (beat_data),
    .beat_idx      (beat_idx),
    .beat_last     (beat_last),
    .done          (done),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] dram_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'd5};
  endfunction

  function automatic logic [31:0] frame_addr(input logic [4:0] f);
    return 32'h0001_0000 + 32'(f) * 32'h1000;
  endfunction

  function automatic logic [127:0] exp_word(input logic [4:0] f, input int i);
    return dram_word(frame_addr(f) + 32'(i) * 32'd16);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DRAM read slave: arready after ar_delay cycles of arvalid, then a gapless burst.
  initial begin : dram_slave
    int   phase;
    int   wait_cnt;
    int   beat;
    logic [31:0] base;
    logic hs_ar, hs_r, smp_rst;
    logic [31:0] smp_addr;
    phase = 0; wait_cnt = 0; beat = 0; base = '0;
    arready_s_inf = 1'b0; rvalid_s_inf = 1'b0; rlast_s_inf = 1'b0;
    rdata_s_inf = '0; rid_s_inf = '0; rresp_s_inf = 2'b00;
    forever begin
      @(posedge clk);
      hs_ar    = arvalid_s_inf && arready_s_inf;
      hs_r     = rvalid_s_inf && rready_s_inf;
      smp_addr = araddr_s_inf;
      smp_rst  = rst;
      #1;
      if (smp_rst) begin
        phase = 0; wait_cnt = 0;
        arready_s_inf = 1'b0; rvalid_s_inf = 1'b0; rlast_s_inf = 1'b0;
      end else begin
        case (phase)
          0: if (arvalid_s_inf) begin
               if (wait_cnt == ar_delay) begin
                 arready_s_inf = 1'b1;
                 phase = 1;
               end else begin
                 wait_cnt++;
               end
             end
          1: if (hs_ar) begin
               arready_s_inf = 1'b0;
               base = smp_addr;
               beat = 0;
               rvalid_s_inf = 1'b1;
               rdata_s_inf  = dram_word(base);
               rlast_s_inf  = (beat == early_last) || (beat == 255);
               phase = 2;
             end
          default: if (hs_r) begin
               if (rlast_s_inf) begin
                 rvalid_s_inf = 1'b0; rlast_s_inf = 1'b0;
                 phase = 0; wait_cnt = 0;
               end else begin
                 beat++;
                 rdata_s_inf = dram_word(base + 32'(beat) * 32'd16);
                 rlast_s_inf = (beat == early_last) || (beat == 255);
               end
             end
        endcase
      end
    end
  end

  initial begin : ready_driver
    beat_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      beat_ready = br_random ? 1'($urandom_range(0, 1)) : br_level;
    end
  end

  // Recorder samples the values the DUT sees at each rising edge.
  initial begin : recorder
    forever begin
      @(posedge clk);
      if (beat_valid && beat_ready) begin
        if (rec_total < REC_DEPTH) begin
          rec_data[rec_total] = beat_data;
          rec_idx[rec_total]  = beat_idx;
          rec_last[rec_total] = beat_last;
        end
        rec_total++;
      end
      if (done) done_total++;
      if (arvalid_s_inf) begin
        ar_high_total++;
        if (ar_prev_valid && (araddr_s_inf !== ar_prev_addr)) ar_addr_changes++;
      end
      if (arvalid_s_inf && arready_s_inf) begin
        ar_hs_total++;
        ar_last_addr = araddr_s_inf;
      end
      ar_prev_valid = arvalid_s_inf;
      ar_prev_addr  = araddr_s_inf;
      if (rst) begin
        occ = 0;
      end else begin
        if (rvalid_s_inf && rready_s_inf) occ++;
        if (beat_valid && beat_ready) occ--;
        if (occ > occ_max) occ_max = occ;
      end
    end
  end

  task automatic snap();
    s_rec  = rec_total;
    s_done = done_total;
    s_ar   = ar_hs_total;
    s_high = ar_high_total;
    s_chg  = ar_addr_changes;
  endtask

  task automatic request(input logic [4:0] f);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_frame_id = f;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_total > s_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic wait_beats(input int target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rec_total >= target) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_beats_reached"}, seen, 1'b1);
  endtask

  task automatic verify_beats(input logic [4:0] f, input int nexp, input string tag);
    int bad;
    int j;
    bad = 0;
    chk({tag, "_beat_count"}, rec_total - s_rec, nexp);
    for (int i = 0; i < nexp; i++) begin
      j = s_rec + i;
      if (j >= REC_DEPTH) bad++;
      else if (rec_idx[j] !== 8'(i) || rec_data[j] !== exp_word(f, i) ||
               rec_last[j] !== (i == nexp - 1)) bad++;
    end
    chk({tag, "_beat_content"}, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready,     1'b1);
    chk({tag, "_arvalid"},    arvalid_s_inf, 1'b0);
    chk({tag, "_rready"},     rready_s_inf,  1'b0);
    chk({tag, "_beat_valid"}, beat_valid,    1'b0);
    chk({tag, "_beat_last"},  beat_last,     1'b0);
    chk({tag, "_done"},       done,          1'b0);
    chk({tag, "_err"},        err,           1'b0);
    chk({tag, "_araddr"},     araddr_s_inf,  32'h0);
    chk({tag, "_beat_data"},  beat_data,     128'h0);
    chk({tag, "_beat_idx"},   beat_idx,      8'h0);
  endtask

  initial begin : main
    rst = 1'b1;
    req_valid = 1'b0;
    req_frame_id = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("arlen",   arlen_s_inf,   8'd255);
    chk("arsize",  arsize_s_inf,  3'b100);
    chk("arburst", arburst_s_inf, 2'b01);
    chk("arid",    arid_s_inf,    4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame 0, immediate arready, beat_ready held high
    snap();
    request(5'd0);
    wait_done("f0");
    repeat (3) @(negedge clk);
    chk("f0_done_once",   done_total - s_done, 1);
    chk("f0_araddr",      ar_last_addr, 32'h0001_0000);
    chk("f0_ar_cycles",   ar_high_total - s_high, 1);
    chk("f0_err",         err, 1'b0);
    chk("f0_idle",        req_ready, 1'b1);
    verify_beats(5'd0, 256, "f0");

    // Frame 31, arready after 5 cycles
    ar_delay = 5;
    snap();
    request(5'd31);
    @(negedge clk);
    chk("f31_arvalid_wait", arvalid_s_inf, 1'b1);
    chk("f31_araddr_out",   araddr_s_inf, 32'h0002_F000);
    wait_done("f31");
    repeat (3) @(negedge clk);
    chk("f31_ar_cycles",     ar_high_total - s_high, 6);
    chk("f31_araddr_stable", ar_addr_changes - s_chg, 0);
    chk("f31_araddr",        ar_last_addr, 32'h0002_F000);
    verify_beats(5'd31, 256, "f31");
    ar_delay = 0;

    // Frame 7 under random backpressure
    br_random = 1'b1;
    snap();
    request(5'd7);
    wait_done("f7");
    repeat (3) @(negedge clk);
    br_random = 1'b0;
    chk("f7_skid_peak", occ_max, 2);
    chk("f7_done_once", done_total - s_done, 1);
    verify_beats(5'd7, 256, "f7");

    // Frame 5 with rlast injected on beat 100
    early_last = 100;
    snap();
    request(5'd5);
    wait_done("f5");
    repeat (3) @(negedge clk);
    early_last = 255;
    chk("f5_err",       err, 1'b1);
    chk("f5_idle",      req_ready, 1'b1);
    chk("f5_done_once", done_total - s_done, 1);
    verify_beats(5'd5, 101, "f5");

    // Next request clears the sticky error
    snap();
    request(5'd6);
    @(negedge clk);
    chk("f6_err_cleared", err, 1'b0);
    wait_done("f6");
    repeat (3) @(negedge clk);
    chk("f6_err", err, 1'b0);
    verify_beats(5'd6, 256, "f6");

    // Reset in the middle of frame 2
    snap();
    request(5'd2);
    wait_beats(s_rec + 40, "f2");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame 3 with req_valid held during the burst, then frame 4 back-to-back
    snap();
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_frame_id = 5'd3;
    @(posedge clk); #1;
    req_frame_id = 5'd9;
    wait_beats(s_rec + 200, "f3");
    chk("f3_req_ready_busy", req_ready, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done("f3");
    chk("f3_single_ar", ar_hs_total - s_ar, 1);
    chk("f3_araddr",    ar_last_addr, 32'h0001_3000);
    verify_beats(5'd3, 256, "f3");
    snap();
    request(5'd4);
    wait_done("f4");
    repeat (3) @(negedge clk);
    chk("f4_araddr", ar_last_addr, 32'h0001_4000);
    chk("f4_err",    err, 1'b0);
    verify_beats(5'd4, 256, "f4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
